mem_loader: RTL and testbench

Byte-stream configuration loader for the SNN parameter memory (weights/delays). Accepts framed write bursts from the host-side byte interface (SPI/UART deserialiser) over a valid/ready handshake. Decodes a start address and length, then drives sequential single-cycle write strobes into the parameter memory's `addr`/`data_in`/`write_enable` port. Sits directly upstream of the parameter memory.

---
 rtl/mem_loader.sv | 208 ++++++++++++++++++++
 tb/tb_mem_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: byte-stream loader for the SNN parameter memory.
// Frame: 0xA5, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then LEN data bytes.
// Each data byte becomes one registered single-cycle write strobe.
// Optional feature macro: MEM_LOADER_CHECKSUM_EN. When defined, a trailing
// XOR checksum byte follows the data and is checked in a CHK state.
//
// Handshake: a byte transfers on a rising edge where in_valid & in_ready.
// in_ready is high whenever reset is low (there is no backpressure), and
// in_data is only looked at on a transfer edge.
module mem_loader #(
  parameter int M  = 320,
  parameter int AW = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_we,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_LEN_HI  = 3'd3,
    S_LEN_LO  = 3'd4,
`ifdef MEM_LOADER_CHECKSUM_EN
    S_DATA    = 3'd5,
    S_CHK     = 3'd6
`else
    S_DATA    = 3'd5
`endif
  } state_t;

  localparam logic [16:0] MEM_DEPTH = 17'(M);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  state_t        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [15:0]   count_q, count_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic          suppress_q, suppress_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_data_q, mem_data_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]    xor_q, xor_d;
`endif

  logic          accept;
  logic [15:0]   len_full;
  logic [16:0]   start_ext;
  logic [16:0]   end_ext;
  logic          range_fault;

  assign in_ready    = ~reset;
  assign accept      = in_valid & in_ready;
  // Length and range are only meaningful on the LEN_LO transfer edge.
  assign len_full    = {len_hi_q, in_data};
  assign start_ext   = {1'b0, addr_q};
  assign end_ext     = start_ext + {1'b0, len_full};
  assign range_fault = (start_ext >= MEM_DEPTH) || (end_ext > MEM_DEPTH);

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign done      = done_q;
  assign error     = error_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  // State and datapath registers; reset aborts any frame immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_hi_q   <= '0;
      count_q    <= '0;
      cur_addr_q <= '0;
      suppress_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_hi_q   <= len_hi_d;
      count_q    <= count_d;
      cur_addr_q <= cur_addr_d;
      suppress_q <= suppress_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef MEM_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  // Next-state logic: one step per accepted byte; strobes default low.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_hi_d   = len_hi_q;
    count_d    = count_q;
    cur_addr_d = cur_addr_q;
    suppress_d = suppress_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    done_d     = 1'b0;
    error_d    = error_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (in_data == SYNC_BYTE) begin
            state_d = S_ADDR_HI;
            error_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
        S_ADDR_HI: begin
          addr_d  = {in_data, addr_q[7:0]};
          state_d = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_d  = {addr_q[15:8], in_data};
          state_d = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_hi_d = in_data;
          state_d  = S_LEN_LO;
        end
        S_LEN_LO: begin
          if (range_fault) error_d = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
          xor_d = '0;
`endif
          if (len_full == 16'd0) begin
`ifdef MEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d    = S_DATA;
            count_d    = len_full;
            cur_addr_d = addr_q[AW-1:0];
            suppress_d = range_fault;
          end
        end
        S_DATA: begin
          // A suppressed (out-of-range) frame still consumes its bytes.
          if (!suppress_q) begin
            mem_we_d   = 1'b1;
            mem_addr_d = cur_addr_q;
            mem_data_d = in_data;
          end
          cur_addr_d = cur_addr_q + AW'(1);
          count_d    = count_q - 16'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ in_data;
`endif
          if (count_q == 16'd1) begin
            suppress_d = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (in_data != xor_q) error_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed and randomized frames for mem_loader, checked
// against a frame-level model (range rule, per-byte write list, checksum).
module tb_mem_loader;

  localparam int M  = 320;
  localparam int AW = $clog2(M);
`ifdef MEM_LOADER_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  // Clock / reset
  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_we;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  mem_loader #(.M(M)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .busy(busy), .done(done), .error(error),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected writes as {addr, data}
  logic [AW+7:0] exp_q[$];
  logic [7:0]    payload[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: present one cycle of input, then sample 1ns after the edge.
  task automatic drive(input logic v, input logic [7:0] b);
    in_valid = v;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic maybe_gap(input int gap_mode, input bit first);
    bit g;
    g = (gap_mode == 1 && !first) || (gap_mode == 2 && ($urandom_range(0, 1) == 1));
    if (g) begin
      drive(1'b0, 8'($urandom_range(0, 255)));
      check("gap_we", 32'(mem_we), 32'(1'b0));
      check("gap_done", 32'(done), 32'(1'b0));
    end
  endtask

  // Sends a frame carrying 'payload' to 'start' and checks every cycle.
  task automatic send_frame(input logic [15:0] start, input int gap_mode, input bit bad_cks);
    int            len;
    logic [15:0]   len16;
    bit            fault;
    bit            last;
    logic [7:0]    x;
    logic [AW+7:0] e;
    len   = payload.size();
    len16 = 16'(len);
    x     = 8'h00;
    fault = (int'(start) >= M) || (int'(start) + len > M);
    if (!fault)
      for (int k = 0; k < len; k++) exp_q.push_back({AW'(int'(start) + k), payload[k]});

    drive(1'b1, 8'hA5);
    check("sync_busy", 32'(busy), 32'(1'b1));
    check("sync_err_clr", 32'(error), 32'(1'b0));
    drive(1'b1, start[15:8]);
    drive(1'b1, start[7:0]);
    drive(1'b1, len16[15:8]);
    check("hdr_we", 32'(mem_we), 32'(1'b0));
    drive(1'b1, len16[7:0]);
    check("len_we", 32'(mem_we), 32'(1'b0));
    check("len_done", 32'(done), 32'(len == 0 && !CKS_EN));
    check("len_err", 32'(error), 32'(fault));

    for (int k = 0; k < len; k++) begin
      maybe_gap(gap_mode, k == 0);
      drive(1'b1, payload[k]);
      x    = x ^ payload[k];
      last = (k == len - 1);
      check("data_we", 32'(mem_we), 32'(!fault));
      if (!fault) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e[AW+7:8]));
        check("wr_data", 32'(mem_data), 32'(e[7:0]));
      end
      check("data_done", 32'(done), 32'(last && !CKS_EN));
      check("data_busy", 32'(busy), 32'(!(last && !CKS_EN)));
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    maybe_gap(gap_mode, len == 0);
    drive(1'b1, bad_cks ? (x ^ 8'hFF) : x);
    check("cks_we", 32'(mem_we), 32'(1'b0));
    check("cks_done", 32'(done), 32'(1'b1));
    check("cks_busy", 32'(busy), 32'(1'b0));
`endif
    check("frame_err", 32'(error), 32'(fault || (CKS_EN && bad_cks)));
    check("sb_empty", 32'(exp_q.size()), 32'(0));
    drive(1'b0, 8'h00);
    check("idle_busy", 32'(busy), 32'(1'b0));
    check("idle_done", 32'(done), 32'(1'b0));
    check("idle_we", 32'(mem_we), 32'(1'b0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"}, 32'(mem_we), 32'(1'b0));
    check({tag, "_addr"}, 32'(mem_addr), 32'(0));
    check({tag, "_data"}, 32'(mem_data), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(1'b0));
    check({tag, "_done"}, 32'(done), 32'(1'b0));
    check({tag, "_err"}, 32'(error), 32'(1'b0));
    check({tag, "_rdy"}, 32'(in_ready), 32'(1'b0));
  endtask

  initial begin
    int          len;
    int          sel;
    logic [15:0] start;
    logic [7:0]  junk;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b0;
    #1;
    check("rdy_after_rst", 32'(in_ready), 32'(1'b1));

    // Basic three-byte write at address 0, no gaps
    payload = '{8'h11, 8'h22, 8'h33};
    send_frame(16'h0000, 0, 1'b0);

    // Top of memory with in_valid toggling
    payload = '{8'hAA, 8'hBB};
    send_frame(16'h013E, 1, 1'b0);

    // Range fault one past the end, then a clean frame
    payload = '{8'h01, 8'h02};
    send_frame(16'h013F, 0, 1'b0);
    payload = '{8'h5C};
    send_frame(16'h0010, 0, 1'b0);

    // Bad command byte in IDLE
    drive(1'b1, 8'h5A);
    check("badcmd_err", 32'(error), 32'(1'b1));
    check("badcmd_busy", 32'(busy), 32'(1'b0));
    check("badcmd_we", 32'(mem_we), 32'(1'b0));

    // Zero-length frame
    payload = {};
    send_frame(16'h0005, 0, 1'b0);

    // Reset after the second of four data bytes
    drive(1'b1, 8'hA5);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h20);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h04);
    drive(1'b1, 8'h61);
    check("pre_rst_we0", 32'(mem_we), 32'(1'b1));
    drive(1'b1, 8'h62);
    check("pre_rst_we1", 32'(mem_we), 32'(1'b1));
    check("pre_rst_addr1", 32'(mem_addr), 32'(16'h21));
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    payload = '{8'h71, 8'h72, 8'h73, 8'h74};
    send_frame(16'h0020, 0, 1'b0);

`ifdef MEM_LOADER_CHECKSUM_EN
    payload = '{8'h0F, 8'hF0};
    send_frame(16'h0000, 0, 1'b0);
    send_frame(16'h0000, 0, 1'b1);
`endif

    // Randomized frames, occasionally preceded by a junk byte
    for (int i = 0; i < 10; i++) begin
      len = $urandom_range(0, 6);
      sel = (len == 0) ? 0 : $urandom_range(0, 3);
      case (sel)
        1:       start = 16'(M - len);
        2:       start = 16'(M - len + 1);
        3:       start = 16'($urandom_range(M, 65535));
        default: start = 16'($urandom_range(0, M - 1 - len));
      endcase
      payload = {};
      for (int k = 0; k < len; k++) payload.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) begin
        junk = 8'($urandom_range(0, 8'hA4));
        drive(1'b1, junk);
        check("junk_err", 32'(error), 32'(1'b1));
        check("junk_busy", 32'(busy), 32'(1'b0));
      end
      send_frame(start, $urandom_range(0, 2), CKS_EN && ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
